// File: rtl/xge_tb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xge_tb_pkg
//  Description : Shared types and constants for the packet transmit generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package xge_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        IPG  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Byte lanes of the 64-bit word; LANE7 carries the first byte on the wire
    localparam int LANE0 = 0;
    localparam int LANE1 = 1;
    localparam int LANE2 = 2;
    localparam int LANE3 = 3;
    localparam int LANE4 = 4;
    localparam int LANE5 = 5;
    localparam int LANE6 = 6;
    localparam int LANE7 = 7;

    localparam int c_MAX_LEN_DEFAULT = 9600;

endpackage : xge_tb_pkg
`default_nettype wire

// File: rtl/pkt_tx_word_build.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_tx_word_build
//  Description : Forms one 64-bit packet word: byte pattern, lane order, tail zeroing.
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_tx_word_build
    import xge_tb_pkg::*;
(
    input  logic [10:0] word_idx,
    input  logic [7:0]  pkt_idx,
    input  logic [13:0] pkt_len,
    output logic [63:0] word
);

    for (genvar k = LANE0; k <= LANE7; k++) begin : g_lane
        // Byte offset within the packet carried by this lane
        logic [13:0] w_pos;
        assign w_pos = {word_idx, 3'(LANE7 - k)};
        assign word[k*8 +: 8] = (w_pos < pkt_len) ? (w_pos[7:0] + pkt_idx) : 8'd0;
    end

endmodule : pkt_tx_word_build
`default_nettype wire

// File: rtl/pkt_tx_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_tx_gen
//  Description : Generates runs of fixed-length test packets toward a 10G MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_tx_gen
    import xge_tb_pkg::*;
#(
    parameter int MAX_LEN = c_MAX_LEN_DEFAULT
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic        start,
    input  logic [13:0] pkt_len,
    input  logic [15:0] pkt_count,
    input  logic [7:0]  ipg_cycles,
    input  logic        pkt_tx_full,
    output logic [63:0] pkt_tx_data,
    output logic        pkt_tx_val,
    output logic        pkt_tx_sop,
    output logic        pkt_tx_eop,
    output logic [2:0]  pkt_tx_mod,
    output logic        busy,
    output logic        done,
    output logic [15:0] tx_pkt_cnt
);

    state_t      r_state, w_state_next;
    logic [13:0] r_len;
    logic [15:0] r_count;
    logic [7:0]  r_ipg, r_ipg_cnt, w_ipg_cnt_next;
    logic [10:0] r_last_word, r_word_idx, w_word_next;
    logic [15:0] r_pkt_idx, w_pkt_next;
    logic [15:0] r_tx_pkt_cnt, w_cnt_next;
    logic [63:0] r_data, w_data, w_word;
    logic        r_val, r_sop, r_eop, r_busy, r_done;
    logic        w_val, w_sop, w_eop, w_busy, w_done, w_load, w_start_ok;
    logic [2:0]  r_mod, w_mod;

    assign w_start_ok = (pkt_len != 14'd0) && (32'(pkt_len) <= 32'(MAX_LEN)) &&
                        (pkt_count != 16'd0);

    pkt_tx_word_build u_word_build (
        .word_idx (r_word_idx),
        .pkt_idx  (r_pkt_idx[7:0]),
        .pkt_len  (r_len),
        .word     (w_word)
    );

    always_comb begin
        w_state_next   = r_state;
        w_word_next    = r_word_idx;
        w_pkt_next     = r_pkt_idx;
        w_ipg_cnt_next = r_ipg_cnt;
        w_cnt_next     = r_tx_pkt_cnt;
        w_data         = 64'd0;
        w_val          = 1'b0;
        w_sop          = 1'b0;
        w_eop          = 1'b0;
        w_mod          = 3'd0;
        w_done         = 1'b0;
        w_load         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_cnt_next   = 16'd0;
                    w_word_next  = 11'd0;
                    w_pkt_next   = 16'd0;
                    w_state_next = w_start_ok ? SEND : FIN;
                end
            end
            SEND: begin
                // Backpressure holds the word pointer; the same word is retried
                if (!pkt_tx_full) begin
                    w_val  = 1'b1;
                    w_data = w_word;
                    w_sop  = (r_word_idx == 11'd0);
                    if (r_word_idx == r_last_word) begin
                        w_eop       = 1'b1;
                        w_mod       = r_len[2:0];
                        w_cnt_next  = r_tx_pkt_cnt + 16'd1;
                        w_word_next = 11'd0;
                        w_pkt_next  = r_pkt_idx + 16'd1;
                        if (r_pkt_idx == r_count - 16'd1) begin
                            w_state_next = FIN;
                        end else if (r_ipg != 8'd0) begin
                            w_state_next   = IPG;
                            w_ipg_cnt_next = r_ipg;
                        end
                    end else begin
                        w_word_next = r_word_idx + 11'd1;
                    end
                end
            end
            IPG: begin
                if (r_ipg_cnt == 8'd1) begin
                    w_state_next = SEND;
                end else begin
                    w_ipg_cnt_next = r_ipg_cnt - 8'd1;
                end
            end
            FIN: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
        endcase
        // busy stays up through the done cycle so it covers the whole run
        w_busy = (w_state_next != IDLE) || (r_state == FIN);
    end

    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            r_state      <= IDLE;
            r_len        <= 14'd0;
            r_count      <= 16'd0;
            r_ipg        <= 8'd0;
            r_ipg_cnt    <= 8'd0;
            r_last_word  <= 11'd0;
            r_word_idx   <= 11'd0;
            r_pkt_idx    <= 16'd0;
            r_tx_pkt_cnt <= 16'd0;
            r_data       <= 64'd0;
            r_val        <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_mod        <= 3'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ipg_cnt    <= w_ipg_cnt_next;
            r_word_idx   <= w_word_next;
            r_pkt_idx    <= w_pkt_next;
            r_tx_pkt_cnt <= w_cnt_next;
            r_data       <= w_data;
            r_val        <= w_val;
            r_sop        <= w_sop;
            r_eop        <= w_eop;
            r_mod        <= w_mod;
            r_busy       <= w_busy;
            r_done       <= w_done;
            if (w_load) begin
                r_len       <= pkt_len;
                r_count     <= pkt_count;
                r_ipg       <= ipg_cycles;
                r_last_word <= 11'((pkt_len - 14'd1) >> 3);
            end
        end
    end

    assign pkt_tx_data = r_data;
    assign pkt_tx_val  = r_val;
    assign pkt_tx_sop  = r_sop;
    assign pkt_tx_eop  = r_eop;
    assign pkt_tx_mod  = r_mod;
    assign busy        = r_busy;
    assign done        = r_done;
    assign tx_pkt_cnt  = r_tx_pkt_cnt;

endmodule : pkt_tx_gen
`default_nettype wire

// File: doc/pkt_tx_gen.md
PKT_TX_GEN -- requirements
Module: pkt_tx_gen

Interface
REQ-001 SHALL have parameter MAX_LEN, default 9600, giving the largest accepted packet length in bytes.
REQ-002 SHALL have port clk_156m25, input, 1 bit: the only clock; all logic on its rising edge.
REQ-003 SHALL have port reset_156m25_n, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that begins a run.
REQ-005 SHALL have port pkt_len, input, 14 bits: packet length in bytes, sampled at start.
REQ-006 SHALL have port pkt_count, input, 16 bits: number of packets in the run, sampled at start.
REQ-007 SHALL have port ipg_cycles, input, 8 bits: idle cycles between packets, sampled at start.
REQ-008 SHALL have port pkt_tx_full, input, 1 bit: MAC transmit FIFO full (backpressure).
REQ-009 SHALL have port pkt_tx_data, output, 64 bits: packet word; first byte on [63:56] (LANE7), last on [7:0] (LANE0).
REQ-010 SHALL have ports pkt_tx_val, pkt_tx_sop and pkt_tx_eop, output, 1 bit each: word valid, first word, last word.
REQ-011 SHALL have port pkt_tx_mod, output, 3 bits: valid bytes in the eop word; 0 means all 8.
REQ-012 SHALL have ports busy and done, output, 1 bit each: run in progress, and a one-cycle pulse at run end.
REQ-013 SHALL have port tx_pkt_cnt, output, 16 bits: packets completed in the current or last run.

Function
REQ-014 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-015 SHALL have FSM states IDLE, SEND, IPG and FIN.
REQ-016 SHALL go from IDLE to SEND on start when pkt_len is in 1..MAX_LEN and pkt_count is not 0.
REQ-017 SHALL go from IDLE to FIN on start with any other pkt_len or pkt_count, sending nothing.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL present the next word with pkt_tx_val=1 after an edge in SEND where pkt_tx_full is low.
REQ-020 SHALL present pkt_tx_val=0 and hold its word pointer after an edge in SEND where pkt_tx_full is high (one-cycle reaction).
REQ-021 SHALL assert pkt_tx_sop only on word 0 and pkt_tx_eop only on word ceil(pkt_len/8)-1; both are asserted for an 8-byte-or-shorter packet.
REQ-022 SHALL set pkt_tx_mod = pkt_len mod 8 on the eop word and 0 on all other words.
REQ-023 SHALL set byte i of packet p to (i + p) mod 256, where p is the 0-based packet index mod 256.
REQ-024 SHALL drive bytes beyond pkt_len in the eop word as 0.
REQ-025 SHALL increment tx_pkt_cnt by 1 in the cycle the eop word is presented.
REQ-026 SHALL, after the eop word, go to FIN on the last packet, else to IPG when ipg_cycles > 0, else stay in SEND so the next sop follows the eop in the very next cycle.
REQ-027 SHALL hold pkt_tx_val=0 in IPG for exactly ipg_cycles cycles, then return to SEND.
REQ-028 SHALL pulse done for one cycle in FIN, then go to IDLE.
REQ-029 SHALL hold busy=1 in SEND, IPG and FIN, and 0 in IDLE.
REQ-030 SHALL clear tx_pkt_cnt on an accepted start and hold it afterwards until the next start.
REQ-031 SHALL, when pkt_tx_full is high on the edge that would present the eop word, present eop with correct mod on the first non-full cycle.
REQ-032 SHALL never let the tx_pkt_cnt or word counters wrap: pkt_count ≤ 65535 and words ≤ 1200.

Reset
REQ-033 SHALL, on a reset_156m25_n low edge, set the state to IDLE, pkt_tx_data to 0, val/sop/eop/mod/busy/done to 0, and tx_pkt_cnt to 0.
REQ-034 SHALL, on reset mid-packet, drop val at the next edge with no eop emitted; the MAC is reset alongside.

Structure
REQ-035 SHALL take the state enum, lane index constants LANE0..LANE7 and the MAX_LEN default from a shared package, xge_tb_pkg.
REQ-036 SHALL keep word formation (byte pattern, lane placement, tail zeroing) in one combinational sub-module, pkt_tx_word_build, whose inputs are word index, packet index and pkt_len.

Verification
REQ-037 SHALL cover: pkt_len=64, pkt_count=1, ipg=0, full=0 -> 8 consecutive val words, sop on word 0, eop+mod=0 on word 7, word 0 = 0x0001020304050607, done one cycle later, tx_pkt_cnt=1.
REQ-038 SHALL cover: pkt_len=61, pkt_count=2, ipg=3 -> each packet 8 words, last word mod=5 and [23:0]=0, exactly 3 idle cycles between, word 0 of packet 1 = 0x0102030405060708.
REQ-039 SHALL cover: pkt_len=100, full high for 4 cycles during word 5 -> val low 4 cycles starting one cycle after full rises, no word skipped or duplicated, 13 words total, eop mod=4.
REQ-040 SHALL cover: pkt_len=5, pkt_count=3, ipg=0 -> three single-word packets back-to-back with sop=eop=1 and mod=5, tx_pkt_cnt=3.
REQ-041 SHALL cover: pkt_len=0 or pkt_count=0 -> no val, busy for two cycles, done pulse, tx_pkt_cnt=0; start while busy -> ignored.
REQ-042 SHALL cover: reset asserted mid-packet (word 3 of 8) -> next edge all outputs 0, no eop; after release a new start sends a complete packet.
